// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive buffer.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef struct packed {
    logic frame_err;
    logic parity_err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: host-side valid/ready stream carrying the head-of-FIFO entry.
interface uart_rx_fifo_if;
  import uart_pkg::*;
  logic [UART_DATA_W-1:0] m_data;
  logic m_parity_err;
  logic m_frame_err;
  logic m_valid;
  logic m_ready;
  modport master(output m_data, m_parity_err, m_frame_err, m_valid, input m_ready);
  modport slave(input m_data, m_parity_err, m_frame_err, m_valid, output m_ready);
endinterface

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: saturating event counter with synchronous clear.
module uart_sat_cnt #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || clr) r_cnt <= '0;
    else if (inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
  assign cnt = r_cnt;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive FIFO with per-byte error flags, sticky overflow and error statistics.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH        = 16,
  parameter bit DROP_ERRORED = 1'b0,
  parameter int STAT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   parity_error,
  input  logic                   frame_error,
  uart_rx_fifo_if.master         m,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  output logic [STAT_W-1:0]      parity_err_cnt,
  output logic [STAT_W-1:0]      frame_err_cnt,
  output logic [STAT_W-1:0]      drop_cnt,
  input  logic                   clr_stats
);
  localparam int AW = $clog2(DEPTH);
  uart_rx_entry_t r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd, r_count;
  logic r_ovf;
  logic w_push, w_store, w_empty, w_full, w_pop, w_wr, w_drop;
  uart_rx_entry_t w_head;
  assign w_push  = rx_valid | frame_error;
  assign w_store = w_push & ~(DROP_ERRORED & (parity_error | frame_error));
  assign w_empty = r_wr == r_rd;
  assign w_full  = r_wr == {~r_rd[AW], r_rd[AW-1:0]};
  assign w_pop   = ~w_empty & m.m_ready;
  // a pop in the same cycle frees the slot the write lands in
  assign w_wr    = w_store & (~w_full | w_pop);
  assign w_drop  = w_store & w_full & ~w_pop;
  assign w_head  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= '{frame_err: frame_error, parity_err: parity_error, data: rx_data};
  always_ff @(posedge clk)
    if (rst || clr_stats) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  uart_sat_cnt #(.W(STAT_W)) u_parity (.clk(clk), .rst(rst), .inc(w_push & parity_error), .clr(clr_stats), .cnt(parity_err_cnt));
  uart_sat_cnt #(.W(STAT_W)) u_frame (.clk(clk), .rst(rst), .inc(frame_error), .clr(clr_stats), .cnt(frame_err_cnt));
  uart_sat_cnt #(.W(STAT_W)) u_drop (.clk(clk), .rst(rst), .inc(w_drop), .clr(clr_stats), .cnt(drop_cnt));
  assign m.m_data       = w_head.data;
  assign m.m_parity_err = w_head.parity_err;
  assign m.m_frame_err  = w_head.frame_err;
  assign m.m_valid      = ~w_empty;
  assign count          = r_count;
  assign full           = w_full;
  assign overflow       = r_ovf;
endmodule
